// File: rtl/mmio_map_pkg.sv
// Shared constants and types for the DMA MMIO register map.
// Holds the register offsets, status bit indices and the channel FSM state type.
package mmio_map_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_RDADDR = 4'h2;
  localparam logic [3:0] OFS_WRADDR = 4'h4;
  localparam logic [3:0] OFS_SIZE   = 4'h6;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_CYCLES = 4'hA;

  localparam logic [15:0] CH_STRIDE = 16'h0010;
  localparam logic [15:0] ID_ADDR   = 16'h0040;
  localparam logic [15:0] NCH_ADDR  = 16'h0042;

  localparam logic [63:0] MMIO_MAP_ID = 64'h4D4D_494F_444D_4101;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ch_state_t;

endpackage

// File: rtl/mmio_if.sv
// MMIO bus between the HAL and the register map.
// Writes take effect at the clock edge; read data returns one cycle after rd_en.
interface mmio_if;

  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output rd_data
  );

  modport user (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/mmio_map_channel.sv
// One DMA channel: address/size registers, IDLE/BUSY FSM,
// sticky done/err status and a saturating busy-cycle counter.
module mmio_map_channel
  import mmio_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 17,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_ctrl_i,
  input  logic                  wr_rdaddr_i,
  input  logic                  wr_wraddr_i,
  input  logic                  wr_size_i,
  input  logic                  wr_status_i,
  input  logic [63:0]           wr_data_i,
  input  logic                  done_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [SIZE_WIDTH-1:0] size_o,
  output logic                  go_o,
  output logic [2:0]            status_o,
  output logic [CNT_WIDTH-1:0]  cycles_o
);

  ch_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
  logic                  go_q, go_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  go_wr;

  assign go_wr = wr_ctrl_i && wr_data_i[0];

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      size_q    <= '0;
      cycles_q  <= '0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      size_q    <= size_d;
      cycles_q  <= cycles_d;
      go_q      <= go_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next state: register writes, start/finish, and sticky status where set beats W1C.
  always_comb begin
    logic done_set;
    logic done_clr;
    logic err_set;
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    size_d    = size_q;
    cycles_d  = cycles_q;
    go_d      = 1'b0;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_rdaddr_i) rd_addr_d = wr_data_i[ADDR_WIDTH-1:0];
        if (wr_wraddr_i) wr_addr_d = wr_data_i[ADDR_WIDTH-1:0];
        if (wr_size_i)   size_d    = wr_data_i[SIZE_WIDTH-1:0];
        if (go_wr) begin
          done_clr = 1'b1;
          cycles_d = '0;
          if (size_q == '0) begin
            done_set = 1'b1;
          end else begin
            go_d    = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cycles_q != '1) cycles_d = cycles_q + CNT_WIDTH'(1);
        if (go_wr || wr_rdaddr_i || wr_wraddr_i || wr_size_i)
          err_set = 1'b1;
        if (done_i) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = done_q;
    err_d  = err_q;
    if (wr_status_i && wr_data_i[ST_DONE]) done_d = 1'b0;
    if (wr_status_i && wr_data_i[ST_ERR])  err_d  = 1'b0;
    if (done_clr) done_d = 1'b0;
    if (done_set) done_d = 1'b1;
    if (err_set)  err_d  = 1'b1;
  end

  assign rd_addr_o = rd_addr_q;
  assign wr_addr_o = wr_addr_q;
  assign size_o    = size_q;
  assign go_o      = go_q;
  assign cycles_o  = cycles_q;
  assign status_o  = {err_q, done_q, state_q == BUSY};

endmodule

// File: rtl/mmio_dma_regmap.sv
// Multi-channel DMA register map: write decode into per-channel strobes,
// registered read mux, and the ID/NCH constant registers.
module mmio_dma_regmap
  import mmio_map_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          ADDR_WIDTH = 64,
  parameter int          SIZE_WIDTH = 17,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [15:0] BASE_ADDR  = 16'h0050
) (
  input  logic                                clk,
  input  logic                                rst_n,
  mmio_if.user                                mmio,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   wr_addr,
  output logic [NUM_CH-1:0][SIZE_WIDTH-1:0]   size,
  output logic [NUM_CH-1:0]                   go,
  input  logic [NUM_CH-1:0]                   done
);

  localparam logic [15:0] END_ADDR =
    BASE_ADDR + 16'(NUM_CH) * CH_STRIDE;

  logic [15:0] wofs, rofs;
  logic        wr_hit, rd_hit;
  logic [63:0] rd_data_q, rd_data_d;

  logic [NUM_CH-1:0][2:0]           status_w;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cycles_w;

  assign wofs = mmio.wr_addr - BASE_ADDR;
  assign rofs = mmio.rd_addr - BASE_ADDR;

  assign wr_hit = mmio.wr_en && !mmio.wr_addr[0] &&
                  mmio.wr_addr >= BASE_ADDR &&
                  mmio.wr_addr < END_ADDR;
  assign rd_hit = !mmio.rd_addr[0] &&
                  mmio.rd_addr >= BASE_ADDR &&
                  mmio.rd_addr < END_ADDR;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_hit && wofs[15:4] == 12'(c);

    mmio_map_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SIZE_WIDTH (SIZE_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_ctrl_i   (sel && wofs[3:0] == OFS_CTRL),
      .wr_rdaddr_i (sel && wofs[3:0] == OFS_RDADDR),
      .wr_wraddr_i (sel && wofs[3:0] == OFS_WRADDR),
      .wr_size_i   (sel && wofs[3:0] == OFS_SIZE),
      .wr_status_i (sel && wofs[3:0] == OFS_STATUS),
      .wr_data_i   (mmio.wr_data),
      .done_i      (done[c]),
      .rd_addr_o   (rd_addr[c]),
      .wr_addr_o   (wr_addr[c]),
      .size_o      (size[c]),
      .go_o        (go[c]),
      .status_o    (status_w[c]),
      .cycles_o    (cycles_w[c])
    );
  end

  // Read mux from current (pre-write) register values; holds when no read.
  always_comb begin
    logic [63:0] mux;
    mux = '0;
    if (mmio.rd_addr == ID_ADDR)  mux = MMIO_MAP_ID;
    if (mmio.rd_addr == NCH_ADDR) mux = 64'(NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_hit && rofs[15:4] == 12'(c)) begin
        unique case (rofs[3:0])
          OFS_RDADDR: mux = 64'(rd_addr[c]);
          OFS_WRADDR: mux = 64'(wr_addr[c]);
          OFS_SIZE:   mux = 64'(size[c]);
          OFS_STATUS: mux = 64'(status_w[c]);
          OFS_CYCLES: mux = 64'(cycles_w[c]);
          default:    mux = '0;
        endcase
      end
    end
    rd_data_d = mmio.rd_en ? mux : rd_data_q;
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign mmio.rd_data = rd_data_q;

endmodule

// File: tb/tb_mmio_dma_regmap.sv
// Directed bench for mmio_dma_regmap: register table plus
// hand-written channel run, busy protection, zero size, collision and reset cases.
module tb_mmio_dma_regmap;

  localparam logic [63:0] EXP_ID = 64'h4D4D_494F_444D_4101;

  logic clk;
  logic rst_n;
  logic [3:0][63:0] rd_addr;
  logic [3:0][63:0] wr_addr;
  logic [3:0][16:0] size;
  logic [3:0]       go;
  logic [3:0]       done;

  int errors;
  int checks;

  mmio_if mif ();

  mmio_dma_regmap dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mmio    (mif),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .size    (size),
    .go      (go),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mif.wr_en   = 1'b1;
    mif.wr_addr = a;
    mif.wr_data = d;
    tick();
    mif.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    mif.rd_en   = 1'b1;
    mif.rd_addr = a;
    tick();
    mif.rd_en   = 1'b0;
    d = mif.rd_data;
  endtask

  task automatic rw(input logic [15:0] a, input logic [63:0] wd,
                    output logic [63:0] d);
    mif.wr_en   = 1'b1;
    mif.wr_addr = a;
    mif.wr_data = wd;
    mif.rd_en   = 1'b1;
    mif.rd_addr = a;
    tick();
    mif.wr_en   = 1'b0;
    mif.rd_en   = 1'b0;
    d = mif.rd_data;
  endtask

  initial begin
    logic [63:0] d;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    done = '0;
    mif.wr_en = 1'b0;
    mif.wr_addr = '0;
    mif.wr_data = '0;
    mif.rd_en = 1'b0;
    mif.rd_addr = '0;

    tbl[0]  = '{1'b0, 16'h0042, 64'h0, 64'd4};
    tbl[1]  = '{1'b0, 16'h0040, 64'h0, EXP_ID};
    tbl[2]  = '{1'b0, 16'h0058, 64'h0, 64'h0};
    tbl[3]  = '{1'b0, 16'h008A, 64'h0, 64'h0};
    tbl[4]  = '{1'b1, 16'h0052, 64'hDEAD_BEEF_0123_4567, 64'h0};
    tbl[5]  = '{1'b0, 16'h0052, 64'h0, 64'hDEAD_BEEF_0123_4567};
    tbl[6]  = '{1'b1, 16'h0053, 64'h1, 64'h0};
    tbl[7]  = '{1'b0, 16'h0052, 64'h0, 64'hDEAD_BEEF_0123_4567};
    tbl[8]  = '{1'b1, 16'h0054, 64'h8000_0000_0000_0001, 64'h0};
    tbl[9]  = '{1'b0, 16'h0054, 64'h0, 64'h8000_0000_0000_0001};
    tbl[10] = '{1'b1, 16'h0056, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[11] = '{1'b0, 16'h0056, 64'h0, 64'h0000_0000_0001_FFFF};
    tbl[12] = '{1'b0, 16'h0050, 64'h0, 64'h0};
    tbl[13] = '{1'b1, 16'h005C, 64'h5, 64'h0};
    tbl[14] = '{1'b0, 16'h005C, 64'h0, 64'h0};
    tbl[15] = '{1'b0, 16'h0090, 64'h0, 64'h0};
    tbl[16] = '{1'b1, 16'h0040, 64'h0, 64'h0};
    tbl[17] = '{1'b0, 16'h0040, 64'h0, EXP_ID};

    // reset
    repeat (2) tick();
    check("rst_go", 64'(go), 64'h0);
    check("rst_size", 64'(size), 64'h0);
    check("rst_rdaddr", rd_addr[0] | rd_addr[3], 64'h0);
    check("rst_wraddr", wr_addr[1] | wr_addr[2], 64'h0);
    check("rst_rd_data", mif.rd_data, 64'h0);
    rst_n = 1'b1;

    // register table
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].data);
      end else begin
        rd(tbl[i].addr, d);
        check($sformatf("tbl%0d@%h", i, tbl[i].addr), d, tbl[i].exp);
      end
    end
    check("port_rdaddr0", rd_addr[0], 64'hDEAD_BEEF_0123_4567);
    check("port_size0", 64'(size[0]), 64'h1FFFF);

    // read and write same register in one cycle
    wr(16'h0072, 64'hAAAA);
    rw(16'h0072, 64'hBBBB, d);
    check("rw_prewrite", d, 64'hAAAA);
    rd(16'h0072, d);
    check("rw_after", d, 64'hBBBB);

    // ch1 normal run
    wr(16'h0062, 64'h1000);
    wr(16'h0064, 64'h2000);
    wr(16'h0066, 64'd8);
    wr(16'h0060, 64'h1);
    check("ch1_go", 64'(go), 64'h2);
    check("ch1_rdaddr", rd_addr[1], 64'h1000);
    check("ch1_wraddr", wr_addr[1], 64'h2000);
    check("ch1_size", 64'(size[1]), 64'd8);
    tick();
    check("ch1_go_1cyc", 64'(go), 64'h0);
    repeat (18) tick();
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
    rd(16'h0068, d);
    check("ch1_status", d, 64'b010);
    rd(16'h006A, d);
    check("ch1_cycles", d, 64'd20);

    // ch0 busy protection
    wr(16'h0056, 64'd4);
    wr(16'h0050, 64'h1);
    check("ch0_go", 64'(go), 64'h1);
    wr(16'h0056, 64'd5);
    check("ch0_nogo_a", 64'(go), 64'h0);
    wr(16'h0050, 64'h1);
    check("ch0_nogo_b", 64'(go), 64'h0);
    check("ch0_size_kept", 64'(size[0]), 64'd4);
    rd(16'h0058, d);
    check("ch0_status_err", d, 64'b101);
    wr(16'h0058, 64'h6);
    rd(16'h0058, d);
    check("ch0_status_w1c", d, 64'b001);
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    rd(16'h0058, d);
    check("ch0_status_done", d, 64'b010);

    // ch2 zero size
    wr(16'h0076, 64'h0);
    wr(16'h0070, 64'h1);
    check("ch2_nogo", 64'(go), 64'h0);
    tick();
    check("ch2_nogo_b", 64'(go), 64'h0);
    rd(16'h0078, d);
    check("ch2_status", d, 64'b010);

    // ch3 done vs CTRL collision, ch0/ch1 back-to-back go
    wr(16'h0086, 64'd2);
    wr(16'h0080, 64'h1);
    check("ch3_go", 64'(go), 64'h8);
    done[3] = 1'b1;
    wr(16'h0080, 64'h1);
    done[3] = 1'b0;
    check("ch3_nogo", 64'(go), 64'h0);
    rd(16'h0088, d);
    check("ch3_status", d, 64'b110);
    wr(16'h0050, 64'h1);
    check("b2b_go0", 64'(go), 64'h1);
    wr(16'h0060, 64'h1);
    check("b2b_go1", 64'(go), 64'h2);
    tick();
    check("b2b_go_off", 64'(go), 64'h0);

    // reset mid-BUSY, then stray done
    rst_n = 1'b0;
    tick();
    check("mid_rst_go_a", 64'(go), 64'h0);
    tick();
    check("mid_rst_go_b", 64'(go), 64'h0);
    rst_n = 1'b1;
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    check("post_rst_go", 64'(go), 64'h0);
    for (int c = 0; c < 4; c++) begin
      rd(16'h0058 + 16'(c) * 16'h0010, d);
      check($sformatf("post_rst_status%0d", c), d, 64'h0);
      check($sformatf("post_rst_go_rd%0d", c), 64'(go), 64'h0);
    end
    rd(16'h005A, d);
    check("post_rst_cycles0", d, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
